stack_lifo_param: RTL and testbench

Parametrised LIFO stack, successor to the fixed 2-bit stack used by the datapath. Width and depth are set by parameters. Adds a registered pop output with valid strobe, a combinational top-of-stack peek, an occupancy count, and an almost-full flag. Supports simultaneous push+pop (replace-top) and sticky overflow/underflow error flags. Used as the operand/return stack for the multi-cycle controllers.

---
 rtl/stack_pkg.sv | 24 ++
 rtl/stack_ram.sv | 29 ++
 rtl/stack_lifo_param.sv | 132 +++++++++++++
 tb/tb_stack_lifo_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack: default sizes and the
// ceiling-log2 helper used to size the occupancy counter and RAM address.
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 256;

    // Number of bits needed to index n distinct values (ceil(log2(n))), minimum 1.
    function automatic int clog2(input int n);
        int bits;
        int v;
        bits = 0;
        v    = n - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH storage for the stack: one synchronous write port, one
// asynchronous read port, no reset (stale entries are unreachable via count).
module stack_ram
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the word on an enabled write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_lifo_param.sv
// Parametrised LIFO stack with registered pop output, combinational peek,
// occupancy count, almost-full flag and sticky overflow/underflow errors.
module stack_lifo_param
    import stack_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int CW       = clog2(DEPTH + 1),
    localparam int AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    logic [CW-1:0]    count_q,    count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q,    valid_d;
    logic             ovf_q,      ovf_d;
    logic             udf_q,      udf_d;

    logic             empty_s;
    logic             full_s;
    logic             we_s;
    logic [AW-1:0]    waddr_s;
    logic [AW-1:0]    raddr_s;
    logic [WIDTH-1:0] rdata_s;

    assign empty_s = (count_q == {CW{1'b0}});
    assign full_s  = (count_q == CW'(DEPTH));
    // Read address points at the current top; parked at 0 when empty.
    assign raddr_s = empty_s ? {AW{1'b0}} : AW'(count_q - CW'(1));

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (data_in),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Next-state logic: push/pop decode, replace-top, pass-through and error flags.
    always_comb begin
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = err_clr ? 1'b0 : ovf_q;
        udf_d      = err_clr ? 1'b0 : udf_q;
        we_s       = 1'b0;
        waddr_s    = raddr_s;
        case ({push, pop})
            2'b10: begin
                if (full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    we_s    = 1'b1;
                    waddr_s = AW'(count_q);
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty_s) begin
                    udf_d = 1'b1;
                end else begin
                    data_out_d = rdata_s;
                    valid_d    = 1'b1;
                    count_d    = count_q - CW'(1);
                end
            end
            2'b11: begin
                // Both requests accepted: old top leaves, new word takes its slot.
                if (empty_s) begin
                    data_out_d = data_in;
                    valid_d    = 1'b1;
                end else begin
                    data_out_d = rdata_s;
                    valid_d    = 1'b1;
                    we_s       = 1'b1;
                    waddr_s    = raddr_s;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= {CW{1'b0}};
            data_out_q <= {WIDTH{1'b0}};
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign top         = empty_s ? {WIDTH{1'b0}} : rdata_s;
    assign count       = count_q;
    assign empty       = empty_s;
    assign full        = full_s;
    assign almost_full = (count_q >= CW'(AF_THRESH));
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_stack_lifo_param.sv
// Directed self-checking bench for stack_lifo_param (WIDTH=8, DEPTH=4, AF_THRESH=3).
module tb_stack_lifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    stack_lifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .top         (top),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then land 1 time unit after the edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
        push    = p;
        pop     = q;
        data_in = d;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("rst_top", 32'(top), 32'h0);
        rst = 1'b0;

        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        chk("af_at2", 32'(almost_full), 32'd0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        chk("af_at3", 32'(almost_full), 32'd1);
        chk("push3_count", 32'(count), 32'd3);
        chk("push3_top", 32'(top), 32'h33);
        chk("push3_empty", 32'(empty), 32'd0);

        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pop1_dout", 32'(data_out), 32'h33);
        chk("pop1_valid", 32'(valid_out), 32'd1);
        chk("pop1_count", 32'(count), 32'd2);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pop2_dout", 32'(data_out), 32'h22);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pop3_dout", 32'(data_out), 32'h11);
        chk("pop3_valid", 32'(valid_out), 32'd1);
        chk("pop3_count", 32'(count), 32'd0);
        chk("pop3_empty", 32'(empty), 32'd1);
        chk("pop3_top", 32'(top), 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle_valid", 32'(valid_out), 32'd0);

        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("upop_udf", 32'(underflow), 32'd1);
        chk("upop_valid", 32'(valid_out), 32'd0);
        chk("upop_dout", 32'(data_out), 32'h11);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("udf_beats_clr", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_clr", 32'(underflow), 32'd0);

        step(1'b1, 1'b1, 8'h7E, 1'b0);
        chk("pass_dout", 32'(data_out), 32'h7E);
        chk("pass_valid", 32'(valid_out), 32'd1);
        chk("pass_count", 32'(count), 32'd0);
        chk("pass_flags", {30'd0, overflow, underflow}, 32'd0);

        step(1'b1, 1'b0, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk("rep_dout", 32'(data_out), 32'h02);
        chk("rep_valid", 32'(valid_out), 32'd1);
        chk("rep_count", 32'(count), 32'd2);
        chk("rep_top", 32'(top), 32'h55);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rep_pop1", 32'(data_out), 32'h55);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rep_pop2", 32'(data_out), 32'h01);
        chk("rep_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        end
        chk("full4_full", 32'(full), 32'd1);
        chk("full4_ovf", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 8'hA4, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_top", 32'(top), 32'hA3);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        step(1'b1, 1'b1, 8'h99, 1'b0);
        chk("frep_dout", 32'(data_out), 32'hA3);
        chk("frep_count", 32'(count), 32'd4);
        chk("frep_top", 32'(top), 32'h99);
        chk("frep_ovf", 32'(overflow), 32'd0);

        step(1'b1, 1'b0, 8'hB0, 1'b0);
        step(1'b1, 1'b1, 8'hB1, 1'b0);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        chk("pre_rst_valid", 32'(valid_out), 32'd1);

        push = 1'b1; pop = 1'b0; data_in = 8'hC0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_dout", 32'(data_out), 32'h0);
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_flags", {30'd0, overflow, underflow}, 32'd0);
        push = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_top", 32'(top), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
